vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator. It is the successor to the fixed 640x400 disp_timing and replaces the hard-coded counters inside display_cntrl.
- Horizontal and vertical phases (visible, front porch, sync, back porch) are set by parameters; sync polarity is selectable per axis.
- A pixel-enable input lets the generator run below pxlclk rate.
- A configurable sync delay aligns sync with downstream RGB pipelines.
- It drives px/py/display_en to character and pentagram renderers, and H_SYNC/V_SYNC to the connector.

Parameters:
H_VIS, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SW, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_VIS, 400, visible lines
V_FP, 12, vertical front porch (lines)
V_SW, 2, vertical sync width (lines)
V_BP, 35, vertical back porch (lines)
H_POL, 0, H_SYNC active level (0 = active-low)
V_POL, 1, V_SYNC active level
SYNC_DLY, 0, extra pix_en-qualified stages on H_SYNC/V_SYNC/de_dly (0..7)
CW, 10, width of px/py

Ports:
pxlclk  in  1  clock
reset  in  1  synchronous active-high reset
pix_en  in  1  advance raster one pixel this cycle
px  out  CW  horizontal counter value
py  out  CW  vertical counter value
display_en  out  1  px < H_VIS and py < V_VIS
line_start  out  1  one-cycle pulse, px == 0
frame_start  out  1  one-cycle pulse, px == 0 and py == 0
H_SYNC  out  1  horizontal sync, delayed SYNC_DLY
V_SYNC  out  1  vertical sync, delayed SYNC_DLY
de_dly  out  1  display_en delayed SYNC_DLY
frame_cnt  out  8  frame counter (optional feature)

Behaviour:
- Totals: H_TOT = H_VIS+H_FP+H_SW+H_BP (default 800); V_TOT = V_VIS+V_FP+V_SW+V_BP (default 449).
- Elaboration error if 2^CW < max(H_TOT, V_TOT) or SYNC_DLY > 7.
- Clock and reset: one clock, pxlclk. Reset is synchronous and active-high, on port reset.
- Reset values: hcnt = vcnt = 0; px = py = 0; display_en = line_start = frame_start = 0; H_SYNC = ~H_POL; V_SYNC = ~V_POL; de_dly = 0; all delay stages = inactive; frame_cnt = 0.
- Horizontal phase FSM:
  - States: ACTIVE [0, H_VIS), FRONT [H_VIS, H_VIS+H_FP), SYNC [.., +H_SW), BACK [.., H_TOT).
  - The state advances on the pix_en cycle where hcnt hits the phase boundary.
  - hcnt wraps H_TOT-1 -> 0.
- Vertical phase FSM: same four states on vcnt. vcnt increments only on the pix_en cycle where hcnt wraps; vcnt wraps V_TOT-1 -> 0 on the same cycle.
- Zero-width phases (e.g. H_FP = 0) are skipped; the FSM goes directly to the next state.
- Outputs px, py, display_en, line_start, frame_start are registered. Updated on pix_en cycles, they reflect the counter state of the previous cycle (latency 1).
- H_SYNC/V_SYNC are active (= POL) while the FSM is in SYNC.
- H_SYNC, V_SYNC and de_dly pass through SYNC_DLY further stages that shift only on pix_en.
- pix_en = 0: counters, FSMs, all output registers and delay stages hold.
  - line_start/frame_start are forced 0 on non-pix_en cycles, so each pulse lasts exactly one pxlclk.
- Reset asserted mid-frame: reset values appear on the next edge. After release, the raster restarts at (0,0) with no partial line.
- Reset has priority over pix_en.

Optional Feature:
VGA_TIMING_FRAMECNT_EN
- Defined: frame_cnt increments (mod 256) on each frame_start pulse. It is cleared by reset. Used for cursor and note blink.
- Undefined: frame_cnt is tied to 0 and no counter register is synthesised.

Decomposition:
- Package vga_timing_pkg holds:
  - the phase enum (ACTIVE, FRONT, SYNC, BACK);
  - default timing constants for 640x400@70 and 640x480@60;
  - the H_TOT/V_TOT helper function.
- Sub-module vga_axis_counter (counter + phase FSM, parameters VIS/FP/SW/BP, inputs step, outputs cnt, phase, wrap) is instantiated twice.
  - Horizontal instance: step = pix_en.
  - Vertical instance: step = pix_en & hwrap.

Test Plan:
- Defaults, pix_en = 1, reset released at cycle 3: display_en rises 1 cycle later with px = 0, py = 0. H_SYNC is low for exactly 96 cycles starting when px = 656, with line period 800.
- Defaults, full frame: V_SYNC is high while py is 412..413. frame_start pulses once per 359200 cycles. 256000 display_en cycles are counted per frame.
- pix_en alternating 1/0: line period is 1600 pxlclk. px/py change only after pix_en cycles. line_start is high for exactly 1 pxlclk.
- SYNC_DLY = 2: H_SYNC and de_dly edges lag the undelayed phase edges by exactly 2 pix_en cycles.
- Reset pulsed at px = 300, py = 200: next cycle matches all reset values. After release, px/py resume from 0,0 and frame_start pulses.
- Small config H = 4/1/2/1, V = 2/1/1/1, with VGA_TIMING_FRAMECNT_EN defined: exhaustive cycle-by-cycle match against the model over 3 frames. frame_cnt reads 1, 2, 3. Both wraps are exercised.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared phase encoding, stock 640-wide timings and the line/frame total helper.
// No logic here. The package has no latency or backpressure of its own.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } phase_e;

  // 640x400 @ 70 Hz
  localparam int VGA400_H_VIS = 640;
  localparam int VGA400_H_FP  = 16;
  localparam int VGA400_H_SW  = 96;
  localparam int VGA400_H_BP  = 48;
  localparam int VGA400_V_VIS = 400;
  localparam int VGA400_V_FP  = 12;
  localparam int VGA400_V_SW  = 2;
  localparam int VGA400_V_BP  = 35;

  // 640x480 @ 60 Hz
  localparam int VGA480_H_VIS = 640;
  localparam int VGA480_H_FP  = 16;
  localparam int VGA480_H_SW  = 96;
  localparam int VGA480_H_BP  = 48;
  localparam int VGA480_V_VIS = 480;
  localparam int VGA480_V_FP  = 10;
  localparam int VGA480_V_SW  = 2;
  localparam int VGA480_V_BP  = 33;

  function automatic int axis_tot(input int vis, input int fp, input int sw, input int bp);
    return vis + fp + sw + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping counter and its ACTIVE/FRONT/SYNC/BACK phase FSM.
// cnt/phase move on the edge after step. wrap is combinational. step=0 holds the axis.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int VIS = 640,
  parameter int FP  = 16,
  parameter int SW  = 96,
  parameter int BP  = 48,
  parameter int CW  = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          step,
  output logic [CW-1:0] cnt,
  output phase_e        phase,
  output logic          wrap
);

  localparam int TOT = axis_tot(VIS, FP, SW, BP);
  localparam logic [CW-1:0] LAST_ACT = CW'(VIS - 1);
  localparam logic [CW-1:0] LAST_FP  = CW'(VIS + FP - 1);
  localparam logic [CW-1:0] LAST_SW  = CW'(VIS + FP + SW - 1);
  localparam logic [CW-1:0] LAST     = CW'(TOT - 1);

  // Successor phases skip any phase that has zero width.
  localparam phase_e AFTER_ACT = (FP != 0) ? FRONT : (SW != 0) ? SYNC : (BP != 0) ? BACK : ACTIVE;
  localparam phase_e AFTER_FP  = (SW != 0) ? SYNC : (BP != 0) ? BACK : ACTIVE;
  localparam phase_e AFTER_SW  = (BP != 0) ? BACK : ACTIVE;

  logic [CW-1:0] cnt_q, cnt_d;
  phase_e        phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    wrap    = step && (cnt_q == LAST);
    if (step) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
      case (phase_q)
        ACTIVE:  if (cnt_q == LAST_ACT) phase_d = AFTER_ACT;
        FRONT:   if (cnt_q == LAST_FP)  phase_d = AFTER_FP;
        SYNC:    if (cnt_q == LAST_SW)  phase_d = AFTER_SW;
        BACK:    if (cnt_q == LAST)     phase_d = ACTIVE;
        default: phase_d = ACTIVE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= ACTIVE;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign cnt   = cnt_q;
  assign phase = phase_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing. Outputs lag the counters by one pix_en step; pix_en=0 holds all state.
// With VGA_TIMING_FRAMECNT_EN defined, frame_cnt counts frame_start pulses. Otherwise it is tied to 0.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VIS    = VGA400_H_VIS,
  parameter int H_FP     = VGA400_H_FP,
  parameter int H_SW     = VGA400_H_SW,
  parameter int H_BP     = VGA400_H_BP,
  parameter int V_VIS    = VGA400_V_VIS,
  parameter int V_FP     = VGA400_V_FP,
  parameter int V_SW     = VGA400_V_SW,
  parameter int V_BP     = VGA400_V_BP,
  parameter int H_POL    = 0,
  parameter int V_POL    = 1,
  parameter int SYNC_DLY = 0,
  parameter int CW       = 10
) (
  input  logic          pxlclk,
  input  logic          reset,
  input  logic          pix_en,
  output logic [CW-1:0] px,
  output logic [CW-1:0] py,
  output logic          display_en,
  output logic          line_start,
  output logic          frame_start,
  output logic          H_SYNC,
  output logic          V_SYNC,
  output logic          de_dly,
  output logic [7:0]    frame_cnt
);

  localparam int H_TOT = axis_tot(H_VIS, H_FP, H_SW, H_BP);
  localparam int V_TOT = axis_tot(V_VIS, V_FP, V_SW, V_BP);
  localparam int MAX_TOT = (H_TOT > V_TOT) ? H_TOT : V_TOT;
  localparam logic HS_ACT = (H_POL != 0);
  localparam logic VS_ACT = (V_POL != 0);

  if (SYNC_DLY < 0 || SYNC_DLY > 7 || (64'd1 << CW) < 64'(MAX_TOT)) begin : g_bad_cfg
    $error("vga_timing_gen: CW too narrow for the raster totals, or SYNC_DLY outside 0..7");
  end

  logic [CW-1:0] hcnt, vcnt;
  phase_e        hphase, vphase;
  logic          hwrap, vwrap_unused;

  vga_axis_counter #(.VIS(H_VIS), .FP(H_FP), .SW(H_SW), .BP(H_BP), .CW(CW)) u_hor (
    .clk   (pxlclk),
    .reset (reset),
    .step  (pix_en),
    .cnt   (hcnt),
    .phase (hphase),
    .wrap  (hwrap)
  );

  vga_axis_counter #(.VIS(V_VIS), .FP(V_FP), .SW(V_SW), .BP(V_BP), .CW(CW)) u_ver (
    .clk   (pxlclk),
    .reset (reset),
    .step  (pix_en & hwrap),
    .cnt   (vcnt),
    .phase (vphase),
    .wrap  (vwrap_unused)
  );

  logic [CW-1:0]     px_q, px_d, py_q, py_d;
  logic              line_start_q, line_start_d, frame_start_q, frame_start_d;
  // Stage 0 is aligned with px/py; stage SYNC_DLY drives the pins.
  logic [SYNC_DLY:0] hs_pipe_q, hs_pipe_d, vs_pipe_q, vs_pipe_d, de_pipe_q, de_pipe_d;

  always_comb begin
    px_d          = px_q;
    py_d          = py_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    hs_pipe_d     = hs_pipe_q;
    vs_pipe_d     = vs_pipe_q;
    de_pipe_d     = de_pipe_q;
    if (pix_en) begin
      px_d          = hcnt;
      py_d          = vcnt;
      line_start_d  = (hcnt == '0);
      frame_start_d = (hcnt == '0) && (vcnt == '0);
      hs_pipe_d[0]  = (hphase == SYNC) ? HS_ACT : ~HS_ACT;
      vs_pipe_d[0]  = (vphase == SYNC) ? VS_ACT : ~VS_ACT;
      de_pipe_d[0]  = (hphase == ACTIVE) && (vphase == ACTIVE);
      for (int i = 1; i <= SYNC_DLY; i++) begin
        hs_pipe_d[i] = hs_pipe_q[i-1];
        vs_pipe_d[i] = vs_pipe_q[i-1];
        de_pipe_d[i] = de_pipe_q[i-1];
      end
    end
  end

  always_ff @(posedge pxlclk) begin
    if (reset) begin
      px_q          <= '0;
      py_q          <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      hs_pipe_q     <= {(SYNC_DLY+1){~HS_ACT}};
      vs_pipe_q     <= {(SYNC_DLY+1){~VS_ACT}};
      de_pipe_q     <= '0;
    end else begin
      px_q          <= px_d;
      py_q          <= py_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      hs_pipe_q     <= hs_pipe_d;
      vs_pipe_q     <= vs_pipe_d;
      de_pipe_q     <= de_pipe_d;
    end
  end

  assign px          = px_q;
  assign py          = py_q;
  assign display_en  = de_pipe_q[0];
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign H_SYNC      = hs_pipe_q[SYNC_DLY];
  assign V_SYNC      = vs_pipe_q[SYNC_DLY];
  assign de_dly      = de_pipe_q[SYNC_DLY];

`ifdef VGA_TIMING_FRAMECNT_EN
  logic [7:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_start_d) frame_cnt_d = frame_cnt_q + 8'd1;
  end

  always_ff @(posedge pxlclk) begin
    if (reset) frame_cnt_q <= '0;
    else       frame_cnt_q <= frame_cnt_d;
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: three vga_timing_gen configurations share reset/pix_en and are compared
// every cycle against a raster model built from (x, y) arithmetic and sync-range tests.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] px;
    logic [9:0] py;
    logic       de;
    logic       ls;
    logic       fs;
    logic       hs;
    logic       vs;
    logic       dd;
    logic [7:0] fc;
  } exp_t;

  typedef exp_t [2:0] exp_arr_t;

`ifdef VGA_TIMING_FRAMECNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  // Configurations: 0 = stock 640x400, 1 = tiny 4/1/2/1 x 2/1/1/1, 2 = zero-width porches, deep delay
  localparam int HV [3] = '{640, 4, 6};
  localparam int HF [3] = '{16, 1, 0};
  localparam int HS [3] = '{96, 2, 2};
  localparam int HB [3] = '{48, 1, 0};
  localparam int VV [3] = '{400, 2, 3};
  localparam int VF [3] = '{12, 1, 0};
  localparam int VS [3] = '{2, 1, 1};
  localparam int VB [3] = '{35, 1, 2};
  localparam int DL [3] = '{0, 2, 7};
  localparam bit HP [3] = '{1'b0, 1'b1, 1'b0};
  localparam bit VP [3] = '{1'b1, 1'b0, 1'b1};

  localparam int N_CYC = 16000;

  logic pxlclk = 1'b0;
  logic reset  = 1'b1;
  logic pix_en = 1'b0;

  always #5 pxlclk = ~pxlclk;

  logic [9:0] px0, py0;
  logic [2:0] px1, py1;
  logic [3:0] px2, py2;
  logic       de0, ls0, fs0, hs0, vs0, dd0;
  logic       de1, ls1, fs1, hs1, vs1, dd1;
  logic       de2, ls2, fs2, hs2, vs2, dd2;
  logic [7:0] fc0, fc1, fc2;

  vga_timing_gen u_dut0 (
    .pxlclk(pxlclk), .reset(reset), .pix_en(pix_en),
    .px(px0), .py(py0), .display_en(de0), .line_start(ls0), .frame_start(fs0),
    .H_SYNC(hs0), .V_SYNC(vs0), .de_dly(dd0), .frame_cnt(fc0)
  );

  vga_timing_gen #(
    .H_VIS(4), .H_FP(1), .H_SW(2), .H_BP(1), .V_VIS(2), .V_FP(1), .V_SW(1), .V_BP(1),
    .H_POL(1), .V_POL(0), .SYNC_DLY(2), .CW(3)
  ) u_dut1 (
    .pxlclk(pxlclk), .reset(reset), .pix_en(pix_en),
    .px(px1), .py(py1), .display_en(de1), .line_start(ls1), .frame_start(fs1),
    .H_SYNC(hs1), .V_SYNC(vs1), .de_dly(dd1), .frame_cnt(fc1)
  );

  vga_timing_gen #(
    .H_VIS(6), .H_FP(0), .H_SW(2), .H_BP(0), .V_VIS(3), .V_FP(0), .V_SW(1), .V_BP(2),
    .H_POL(0), .V_POL(1), .SYNC_DLY(7), .CW(4)
  ) u_dut2 (
    .pxlclk(pxlclk), .reset(reset), .pix_en(pix_en),
    .px(px2), .py(py2), .display_en(de2), .line_start(ls2), .frame_start(fs2),
    .H_SYNC(hs2), .V_SYNC(vs2), .de_dly(dd2), .frame_cnt(fc2)
  );

  // Reference raster state: the beam position that the next pix_en step will report
  int   mx [3];
  int   my [3];
  int   mfc [3];
  bit   hsh [3][8];
  bit   vsh [3][8];
  bit   deh [3][8];
  exp_t cur [3];

  exp_arr_t sb_q[$];
  int checks   = 0;
  int failures = 0;
  int mon_cyc  = 0;

  task automatic model_step(input int id, input bit rst, input bit en);
    int hs_lo, vs_lo;
    if (rst) begin
      mx[id]  = 0;
      my[id]  = 0;
      mfc[id] = 0;
      for (int k = 0; k < 8; k++) begin
        hsh[id][k] = 1'b0;
        vsh[id][k] = 1'b0;
        deh[id][k] = 1'b0;
      end
      cur[id] = '{px: 10'd0, py: 10'd0, de: 1'b0, ls: 1'b0, fs: 1'b0,
                  hs: ~HP[id], vs: ~VP[id], dd: 1'b0, fc: 8'd0};
    end else if (en) begin
      hs_lo = HV[id] + HF[id];
      vs_lo = VV[id] + VF[id];
      for (int k = 7; k > 0; k--) begin
        hsh[id][k] = hsh[id][k-1];
        vsh[id][k] = vsh[id][k-1];
        deh[id][k] = deh[id][k-1];
      end
      hsh[id][0] = (mx[id] >= hs_lo) && (mx[id] < hs_lo + HS[id]);
      vsh[id][0] = (my[id] >= vs_lo) && (my[id] < vs_lo + VS[id]);
      deh[id][0] = (mx[id] < HV[id]) && (my[id] < VV[id]);
      cur[id].px = 10'(mx[id]);
      cur[id].py = 10'(my[id]);
      cur[id].de = deh[id][0];
      cur[id].ls = (mx[id] == 0);
      cur[id].fs = (mx[id] == 0) && (my[id] == 0);
      cur[id].hs = hsh[id][DL[id]] ? HP[id] : ~HP[id];
      cur[id].vs = vsh[id][DL[id]] ? VP[id] : ~VP[id];
      cur[id].dd = deh[id][DL[id]];
      if (cur[id].fs && FC_EN) mfc[id] = (mfc[id] + 1) % 256;
      cur[id].fc = 8'(mfc[id]);
      mx[id] = mx[id] + 1;
      if (mx[id] == HV[id] + HF[id] + HS[id] + HB[id]) begin
        mx[id] = 0;
        my[id] = my[id] + 1;
        if (my[id] == VV[id] + VF[id] + VS[id] + VB[id]) my[id] = 0;
      end
    end else begin
      cur[id].ls = 1'b0;
      cur[id].fs = 1'b0;
    end
  endtask

  task automatic check(input string nm, input int id, input logic [9:0] act, input logic [9:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", nm, id, mon_cyc, act, expv);
    end
  endtask

  task automatic compare(input int id, input exp_t a, input exp_t e);
    check("px", id, a.px, e.px);
    check("py", id, a.py, e.py);
    check("display_en", id, 10'(a.de), 10'(e.de));
    check("line_start", id, 10'(a.ls), 10'(e.ls));
    check("frame_start", id, 10'(a.fs), 10'(e.fs));
    check("H_SYNC", id, 10'(a.hs), 10'(e.hs));
    check("V_SYNC", id, 10'(a.vs), 10'(e.vs));
    check("de_dly", id, 10'(a.dd), 10'(e.dd));
    check("frame_cnt", id, 10'(a.fc), 10'(e.fc));
  endtask

  // Stimulus: steady pix_en, then alternating, then random enables with occasional resets
  initial begin
    exp_arr_t e;
    bit r, en;
    for (int c = 0; c < N_CYC; c++) begin
      @(negedge pxlclk);
      if (c < 3)         r = 1'b1;
      else if (c < 4000) r = 1'b0;
      else               r = ($urandom_range(0, 699) == 0);
      if (c < 2000)      en = 1'b1;
      else if (c < 4000) en = c[0];
      else               en = ($urandom_range(0, 3) != 0);
      reset  = r;
      pix_en = en;
      for (int id = 0; id < 3; id++) begin
        model_step(id, r, en);
        e[id] = cur[id];
      end
      sb_q.push_back(e);
    end
    @(negedge pxlclk);
    @(negedge pxlclk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Monitor: every clock edge presents a fresh output set; pop and compare it
  initial begin
    exp_arr_t e;
    exp_t a0, a1, a2;
    forever begin
      @(posedge pxlclk);
      #1;
      if (sb_q.size() != 0) begin
        e  = sb_q.pop_front();
        a0 = '{px: px0, py: py0, de: de0, ls: ls0, fs: fs0, hs: hs0, vs: vs0, dd: dd0, fc: fc0};
        a1 = '{px: 10'(px1), py: 10'(py1), de: de1, ls: ls1, fs: fs1, hs: hs1, vs: vs1, dd: dd1, fc: fc1};
        a2 = '{px: 10'(px2), py: 10'(py2), de: de2, ls: ls2, fs: fs2, hs: hs2, vs: vs2, dd: dd2, fc: fc2};
        compare(0, a0, e[0]);
        compare(1, a1, e[1]);
        compare(2, a2, e[2]);
        mon_cyc++;
      end
    end
  end

endmodule
